// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its consumers.
// Key codes are row*4 + col for the usual 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D layout.
package keypad_pkg;

  localparam int unsigned NUM_LINES = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_RELEASE  = 2'd2;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  // Index of the lowest active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low_col(input logic [NUM_LINES-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad column pins.
// Resets to all-ones so an idle (pulled-up) keypad reads as no key.
module sync_2ff
  import keypad_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_LINES-1:0] i_async,
  output logic [NUM_LINES-1:0] o_sync
);

  logic [NUM_LINES-1:0] r_meta;
  logic [NUM_LINES-1:0] r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the active-low row drive, debounces presses and
// releases, and emits one key_valid pulse per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]        w_col;
  logic              w_any_low;
  logic [1:0]        w_low_col;
  logic              w_match;

  state_t            r_state,    w_state_d;
  logic [1:0]        r_row,      w_row_d;
  logic [SCAN_W-1:0] r_scan_cnt, w_scan_cnt_d;
  logic [DEB_W-1:0]  r_deb_cnt,  w_deb_cnt_d;
  logic [1:0]        r_cand_col, w_cand_col_d;
  logic [3:0]        r_key_code, w_key_code_d;
  logic              r_key_valid, w_key_valid_d;
  logic              r_key_held,  w_key_held_d;

  sync_2ff u_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_async (col_in),
    .o_sync  (w_col)
  );

  assign w_any_low = ~&w_col;
  assign w_low_col = lowest_low_col(w_col);
  // Row is frozen outside SCAN, so comparing the column alone compares the full code.
  assign w_match   = w_any_low && (w_low_col == r_cand_col);

  always_comb begin
    w_state_d     = r_state;
    w_row_d       = r_row;
    w_scan_cnt_d  = r_scan_cnt;
    w_deb_cnt_d   = r_deb_cnt;
    w_cand_col_d  = r_cand_col;
    w_key_code_d  = r_key_code;
    w_key_valid_d = 1'b0;
    w_key_held_d  = r_key_held;

    case (r_state)
      ST_SCAN: begin
        if (w_any_low) begin
          w_state_d    = ST_DEBOUNCE;
          w_cand_col_d = w_low_col;
          w_deb_cnt_d  = '0;
          w_scan_cnt_d = '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
          w_scan_cnt_d = '0;
          w_row_d      = r_row + 2'd1;
        end else begin
          w_scan_cnt_d = r_scan_cnt + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (!w_match) begin
          w_state_d   = ST_SCAN;
          w_deb_cnt_d = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_d     = ST_RELEASE;
          w_key_code_d  = {r_row, r_cand_col};
          w_key_valid_d = 1'b1;
          w_key_held_d  = 1'b1;
          w_deb_cnt_d   = '0;
        end else begin
          w_deb_cnt_d = r_deb_cnt + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Any low column (same key bouncing or a second key) restarts the release window.
        if (w_any_low) begin
          w_deb_cnt_d = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_d    = ST_SCAN;
          w_key_held_d = 1'b0;
          w_row_d      = r_row + 2'd1;
          w_deb_cnt_d  = '0;
        end else begin
          w_deb_cnt_d = r_deb_cnt + 1'b1;
        end
      end

      default: begin
        w_state_d   = ST_SCAN;
        w_deb_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_row       <= 2'd0;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_cand_col  <= 2'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_row       <= w_row_d;
      r_scan_cnt  <= w_scan_cnt_d;
      r_deb_cnt   <= w_deb_cnt_d;
      r_cand_col  <= w_cand_col_d;
      r_key_code  <= w_key_code_d;
      r_key_valid <= w_key_valid_d;
      r_key_held  <= w_key_held_d;
    end
  end

  assign row_out   = ~(4'b0001 << r_row);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Upstream stage feeding key_input / user_value to gamelogic_top: scans a 4x4 matrix keypad, debounces it and emits one code per press.

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each row is driven before rotating to the next row.
REQ-002 Parameter DEBOUNCE_CNT, default 100000: consecutive stable cycles required to accept a press or a release.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col_in  input  4  keypad column pins, active-low, asynchronous to clock.
REQ-006 row_out  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of last accepted key: row*4 + col.
REQ-008 key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-009 key_held  output  1  high from the key_valid cycle until the release is accepted.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer before any use; all later references mean the synchronized value.
REQ-011 States: SCAN, DEBOUNCE, RELEASE.
REQ-012 SCAN, no column low: row counter advances every SCAN_DIV cycles, in the order 0 -> 1 -> 2 -> 3 -> 0.
- Row r drives row_out = ~(1 << r).
REQ-013 SCAN, any column low: freeze the row, capture candidate code = row*4 + lowest low column index, clear the debounce counter, go to DEBOUNCE.
REQ-014 DEBOUNCE: the counter increments each cycle while the candidate code still matches.
- On a mismatch or all columns high: return to SCAN, counter cleared, row not advanced.
REQ-015 DEBOUNCE, counter reaches DEBOUNCE_CNT-1 with a match: load key_code, pulse key_valid for exactly 1 cycle, set key_held, go to RELEASE.
REQ-016 Latency: for a stable press on the active row, key_valid SHALL assert exactly DEBOUNCE_CNT+3 rising edges after the column pin falls.
REQ-017 RELEASE: the counter counts consecutive all-columns-high cycles and clears on any low column.
- On reaching DEBOUNCE_CNT-1: clear key_held, advance the row by one (wrap 3 -> 0), go to SCAN.
REQ-018 At most one key_valid per physical press; a second key pressed during RELEASE is ignored until full release.
REQ-019 Simultaneous keys on the active row: the lowest column index wins. Keys on other rows are not seen until their row is driven.
REQ-020 key_code SHALL hold its value between pulses and is never cleared except by reset.
REQ-021 Counters SHALL saturate at their terminal value and never wrap.
- Counter widths: $clog2 of the respective parameter.

Reset
REQ-022 On reset (sampled at a rising edge):
- row_out = 4'b1110; key_code = 0; key_valid = 0; key_held = 0.
- State SCAN; both counters 0; synchronizer flops 4'b1111.
REQ-023 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL abort without emitting key_valid and takes priority over all transitions.

Structure
REQ-024 Package keypad_pkg SHALL hold the state enum, the row/column count constant (4) and the named key-code constants used by gamelogic_top.
REQ-025 One sub-module, sync_2ff, SHALL implement the 4-bit two-flop synchronizer; everything else stays in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-026 Reset, no keys -> row_out cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid never asserts.
REQ-027 col_in=1101 held while row 2 is driven -> key_valid exactly 11 edges after the pin falls; key_code=9 (2*4+1); key_held=1.
REQ-028 Bouncing press, 3 cycles low / 2 high repeated, then stable low -> one key_valid only, counted from the start of the stable interval.
REQ-029 Hold the key 100 cycles, release for 5 cycles, re-press -> no second pulse; after a release of 8+ cycles plus a new press, a second pulse occurs.
REQ-030 col_in=1100 on row 0 -> key_code=0 (column 0 wins).
REQ-031 Reset at DEBOUNCE count 5 -> no key_valid; outputs at reset values the next cycle.
